// File: rtl/cache_pkg.sv
// Shared types and AXI constants for the cache-side sram_like responders.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/inst_sram_like_axi_rd.sv
// Instruction-side sram_like responder; one outstanding single-beat AXI read.
module inst_sram_like_axi_rd
    import cache_pkg::*;
#(
    parameter int                  AXI_ID_W = 4,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inst_req_i,
    input  logic                inst_wr_i,
    input  logic [1:0]          inst_size_i,
    input  logic [31:0]         inst_addr_i,
    input  logic [31:0]         inst_wdata_i,
    output logic                inst_addr_ok_o,
    output logic                inst_data_ok_o,
    output logic [31:0]         inst_rdata_o,
    output logic [AXI_ID_W-1:0] arid_o,
    output logic [31:0]         araddr_o,
    output logic [7:0]          arlen_o,
    output logic [2:0]          arsize_o,
    output logic [1:0]          arburst_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [AXI_ID_W-1:0] rid_i,
    input  logic [31:0]         rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic                err_o
);

    state_e      r_state;
    logic        r_data_ok;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_araddr;
    logic [1:0]  r_size;
    logic        w_unused_wdata;

    assign w_unused_wdata = ^inst_wdata_i;

    assign inst_addr_ok_o = (r_state == ST_IDLE) & inst_req_i & ~rst_i;
    assign inst_data_ok_o = r_data_ok;
    assign inst_rdata_o   = r_rdata;
    assign arid_o         = AXI_ID;
    assign araddr_o       = r_araddr;
    assign arlen_o        = 8'd0;
    assign arsize_o       = {1'b0, r_size};
    assign arburst_o      = AXI_BURST_INCR;
    assign arvalid_o      = r_arvalid;
    assign rready_o       = r_rready;
    assign err_o          = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_data_ok <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_araddr  <= '0;
            r_size    <= SIZE_BYTE;
        end else begin
            r_data_ok <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (inst_req_i && inst_wr_i) begin
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                        r_data_ok <= 1'b1;
                        r_state   <= ST_RESP;
                    end else if (inst_req_i) begin
                        r_araddr  <= inst_addr_i;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                        // size 3 has no sram_like meaning: fetch a word, flag it
                        if (inst_size_i == 2'b11) begin
                            r_size <= SIZE_WORD;
                            r_err  <= 1'b1;
                        end else begin
                            r_size <= inst_size_i;
                        end
                    end
                end
                ST_AR: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid_i && rid_i == AXI_ID) begin
                        r_rdata   <= rdata_i;
                        r_rready  <= 1'b0;
                        r_data_ok <= 1'b1;
                        r_state   <= ST_RESP;
                        if (rresp_i != AXI_RESP_OKAY || !rlast_i) begin
                            r_err <= 1'b1;
                        end
                    end else if (rvalid_i) begin
                        r_err <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_sram_like_axi_rd.sv
// Scoreboard bench for the instruction-side sram_like AXI read responder.
module tb_inst_sram_like_axi_rd;

    localparam logic [3:0] TB_ID  = 4'h0;
    localparam logic [3:0] BAD_ID = 4'h5;

    logic        clk_i;
    logic        rst_i;
    logic        inst_req_i;
    logic        inst_wr_i;
    logic [1:0]  inst_size_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_wdata_i;
    logic        inst_addr_ok_o;
    logic        inst_data_ok_o;
    logic [31:0] inst_rdata_o;
    logic [3:0]  arid_o;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [3:0]  rid_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    logic        err_o;

    inst_sram_like_axi_rd #(
        .AXI_ID_W(4),
        .AXI_ID  (TB_ID)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .inst_req_i    (inst_req_i),
        .inst_wr_i     (inst_wr_i),
        .inst_size_i   (inst_size_i),
        .inst_addr_i   (inst_addr_i),
        .inst_wdata_i  (inst_wdata_i),
        .inst_addr_ok_o(inst_addr_ok_o),
        .inst_data_ok_o(inst_data_ok_o),
        .inst_rdata_o  (inst_rdata_o),
        .arid_o        (arid_o),
        .araddr_o      (araddr_o),
        .arlen_o       (arlen_o),
        .arsize_o      (arsize_o),
        .arburst_o     (arburst_o),
        .arvalid_o     (arvalid_o),
        .arready_i     (arready_i),
        .rid_i         (rid_i),
        .rdata_i       (rdata_i),
        .rresp_i       (rresp_i),
        .rlast_i       (rlast_i),
        .rvalid_i      (rvalid_i),
        .rready_o      (rready_o),
        .err_o         (err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_dok  = 0;

    logic [31:0] exp_q[$];
    logic [34:0] ar_q[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h3C08_BFC0;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return ~a;
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i && inst_data_ok_o) begin
            n_dok++;
            if (exp_q.size() == 0) check("unexpected_data_ok", 1, 0);
            else check("rdata", inst_rdata_o, exp_q.pop_front());
        end
        if (!rst_i && arvalid_o && arready_i) begin
            if (ar_q.size() == 0) begin
                check("unexpected_ar", 1, 0);
            end else begin
                logic [34:0] e;
                e = ar_q.pop_front();
                check("ar_addr", araddr_o, e[34:3]);
                check("ar_size", {29'd0, arsize_o}, {29'd0, e[2:0]});
            end
        end
    end

    // Called #1 after a posedge with the DUT idle; returns likewise.
    task automatic read_txn(input logic [31:0] a, input logic [1:0] sz,
                            input logic [1:0] resp, input int ar_dly,
                            input int r_dly, input bit hold,
                            input bit bad_rid);
        int lat;
        int d0;
        logic [2:0] esz;
        esz = (sz == 2'b11) ? 3'b010 : {1'b0, sz};
        inst_req_i  = 1'b1;
        inst_wr_i   = 1'b0;
        inst_addr_i = a;
        inst_size_i = sz;
        #1 check("addr_ok", inst_addr_ok_o, 1);
        ar_q.push_back({a, esz});
        if (!bad_rid) exp_q.push_back(mem(a));
        d0 = n_dok;
        @(posedge clk_i); #1;
        lat = 1;
        if (!hold) inst_req_i = 1'b0;
        #1 check("busy_addr_ok", inst_addr_ok_o, 0);
        for (int i = 0; i < ar_dly; i++) begin
            check("arvalid_hold", arvalid_o, 1);
            check("araddr_hold", araddr_o, a);
            check("busy_addr_ok_ar", inst_addr_ok_o, 0);
            @(posedge clk_i); #2;
            lat++;
        end
        check("arvalid", arvalid_o, 1);
        arready_i = 1'b1;
        @(posedge clk_i); #1;
        arready_i = 1'b0;
        lat++;
        for (int i = 0; i < r_dly; i++) begin
            check("rready_wait", rready_o, 1);
            check("arvalid_low_r", arvalid_o, 0);
            check("busy_addr_ok_r", inst_addr_ok_o, 0);
            @(posedge clk_i); #1;
            lat++;
        end
        rvalid_i = 1'b1;
        rid_i    = bad_rid ? BAD_ID : TB_ID;
        rdata_i  = mem(a);
        rresp_i  = resp;
        rlast_i  = 1'b1;
        @(posedge clk_i); #1;
        rvalid_i = 1'b0;
        lat++;
        if (bad_rid) return;
        #1 check("data_ok", inst_data_ok_o, 1);
        check("resp_addr_ok", inst_addr_ok_o, 0);
        if (ar_dly == 0 && r_dly == 0) check("latency", lat, 3);
        @(posedge clk_i); #1;
        check("one_data_ok", n_dok - d0, 1);
    endtask

    task automatic write_txn(input logic [31:0] a);
        inst_req_i  = 1'b1;
        inst_wr_i   = 1'b1;
        inst_addr_i = a;
        inst_size_i = 2'b10;
        #1 check("wr_addr_ok", inst_addr_ok_o, 1);
        exp_q.push_back(32'd0);
        @(posedge clk_i); #1;
        inst_req_i = 1'b0;
        inst_wr_i  = 1'b0;
        check("wr_data_ok", inst_data_ok_o, 1);
        check("wr_no_arvalid", arvalid_o, 0);
        check("wr_err", err_o, 1);
        @(posedge clk_i); #1;
        check("wr_no_arvalid2", arvalid_o, 0);
    endtask

    initial begin
        rst_i        = 1'b1;
        inst_req_i   = 1'b0;
        inst_wr_i    = 1'b0;
        inst_size_i  = 2'b10;
        inst_addr_i  = '0;
        inst_wdata_i = 32'h1234_5678;
        arready_i    = 1'b0;
        rid_i        = '0;
        rdata_i      = '0;
        rresp_i      = '0;
        rlast_i      = 1'b0;
        rvalid_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        check("rst_addr_ok", inst_addr_ok_o, 0);
        check("rst_data_ok", inst_data_ok_o, 0);
        check("rst_arvalid", arvalid_o, 0);
        check("rst_rready", rready_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata", inst_rdata_o, 0);
        check("rst_araddr", araddr_o, 0);
        check("arlen", arlen_o, 0);
        check("arburst", arburst_o, 2'b01);
        check("arid", arid_o, TB_ID);

        read_txn(32'hBFC0_0000, 2'b10, 2'b00, 0, 0, 0, 0);
        check("word_err", err_o, 0);

        read_txn(32'h0000_0040, 2'b10, 2'b00, 5, 3, 1, 0);
        inst_req_i = 1'b0;

        read_txn(32'h0000_0000, 2'b10, 2'b00, 0, 0, 1, 0);
        read_txn(32'h0000_0004, 2'b10, 2'b00, 0, 0, 0, 0);

        read_txn(32'h0000_0003, 2'b00, 2'b00, 0, 0, 0, 0);
        check("byte_err", err_o, 0);
        check("rdata_hold", inst_rdata_o, mem(32'h3));

        read_txn(32'h0000_0100, 2'b10, 2'b10, 0, 0, 0, 0);
        check("rresp_err", err_o, 1);

        write_txn(32'h0000_0200);
        check("wr_err_sticky", err_o, 1);

        read_txn(32'h0000_0300, 2'b10, 2'b00, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("badrid_no_data_ok", inst_data_ok_o, 0);
            check("badrid_rready", rready_o, 1);
            @(posedge clk_i); #1;
        end
        check("badrid_err", err_o, 1);

        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("mid_rst_addr_ok", inst_addr_ok_o, 0);
        check("mid_rst_data_ok", inst_data_ok_o, 0);
        check("mid_rst_arvalid", arvalid_o, 0);
        check("mid_rst_rready", rready_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_rdata", inst_rdata_o, 0);
        check("mid_rst_araddr", araddr_o, 0);

        read_txn(32'h0000_0010, 2'b10, 2'b00, 0, 0, 0, 0);
        check("post_rst_err", err_o, 0);

        read_txn(32'h0000_0020, 2'b11, 2'b00, 0, 0, 0, 0);
        check("size3_err", err_o, 1);

        repeat (2) @(posedge clk_i);
        #1 check("queues_empty", exp_q.size() + ar_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_sram_like_axi_rd.md
Name: inst_sram_like_axi_rd

Overview:
- Responder (slave) end of the instruction-side sram_like protocol. Accepts req/addr from the CPU-side sram_like initiator and returns addr_ok/data_ok/rdata.
- Serves each accepted request with a single-beat AXI4 read (AR/R channels). Sits between the instruction fetch bridge and the AXI crossbar.
- At most one outstanding transaction. Every accepted request is always completed, even if the initiator has since flushed and will discard the data.

Parameters:
- AXI_ID_W, 4, width of arid/rid
- AXI_ID, 4'h0, fixed ID driven on arid_o and expected on rid_i

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- inst_req_i  in  1  sram_like request
- inst_wr_i  in  1  write flag; unsupported, error-completed
- inst_size_i  in  2  0=byte, 1=half, 2=word
- inst_addr_i  in  32  request address
- inst_wdata_i  in  32  unused; ignored
- inst_addr_ok_o  out  1  address accepted this cycle
- inst_data_ok_o  out  1  one-cycle pulse, rdata valid
- inst_rdata_o  out  32  read data
- arid_o  out  AXI_ID_W  = AXI_ID
- araddr_o  out  32  latched address
- arlen_o  out  8  constant 0
- arsize_o  out  3  {1'b0, size}
- arburst_o  out  2  constant 2'b01 (INCR)
- arvalid_o  out  1  AR valid
- arready_i  in  1  AR ready
- rid_i  in  AXI_ID_W  R id
- rdata_i  in  32  R data
- rresp_i  in  2  R response
- rlast_i  in  1  R last
- rvalid_i  in  1  R valid
- rready_o  out  1  R ready
- err_o  out  1  sticky error flag

Behaviour:
- Reset (synchronous, rst_i=1 at posedge):
  - State goes to IDLE.
  - inst_addr_ok_o, inst_data_ok_o, arvalid_o, rready_o, err_o go to 0.
  - inst_rdata_o and araddr_o go to 0.
  - Reset mid-transaction abandons the transaction without completing AXI. System-wide reset is required.
- FSM states: IDLE, AR, R, RESP.
- IDLE:
  - inst_addr_ok_o = inst_req_i (combinational).
  - On req & ~wr: latch addr and size, go to AR.
  - On req & wr: set err, load rdata 0, go to RESP. No AXI traffic.
  - Size 2'b11 is issued as word (arsize=3'b010) and sets err.
- AR:
  - arvalid_o=1. araddr/arsize are registered and stable until the handshake.
  - On arready_i go to R. Waits indefinitely otherwise.
- R:
  - rready_o=1.
  - On rvalid_i & rid_i==AXI_ID: latch rdata_i into inst_rdata_o and go to RESP.
  - rresp_i!=0 or rlast_i==0 on that beat sets err; data is still returned.
  - rvalid_i with a mismatched rid: beat is consumed and dropped, err is set, FSM stays in R.
- RESP:
  - inst_data_ok_o=1 for exactly one cycle, then go to IDLE.
  - inst_addr_ok_o=0 in AR, R and RESP. A new request is accepted only from IDLE, i.e. the cycle after data_ok.
- inst_rdata_o holds its last value until the next completion.
- Latency: addr_ok at cycle 0, arvalid from cycle 1. With arready and rvalid both immediate, data_ok at cycle 3. Minimum request-to-request spacing is 4 cycles.
- err_o is sticky and cleared only by reset.
- arvalid_o never deasserts before arready_i. rready_o is asserted only in R.

Decomposition:
- Shared package (cache_pkg): state enum typedef; AXI constants (AXI_BURST_INCR, AXI_RESP_OKAY, SIZE_BYTE/HALF/WORD).
- No sub-module; a single FSM with registered outputs is natural.
- Optional shared sub-module axi_rd_single_beat (AR/R channels only), reusable by the data-side responder.

Test Plan:
- Word read, addr 0xBFC00000: arready and rvalid immediate, rdata 0x3C08BFC0, rresp 0. Expect addr_ok at c0, arvalid at c1, data_ok at c3 with rdata 0x3C08BFC0, err 0.
- Backpressure: arready held 0 for 5 cycles, rvalid delayed 3 cycles. Expect araddr/arvalid stable throughout, exactly one data_ok, and addr_ok=0 while busy even with req held 1.
- Back-to-back: req held high for two addresses 0x0 then 0x4. Expect the second addr_ok in the cycle after the first data_ok, and two AR handshakes in order.
- Error cases, each expecting err_o=1 and sticky:
  - rresp=2'b10 with data 0xDEADBEEF: data_ok with 0xDEADBEEF.
  - Mismatched rid beat: dropped, no data_ok.
  - wr=1 request: data_ok with rdata 0 and no arvalid.
- Reset mid-R: rst_i asserted for 1 cycle while in R. Expect all outputs 0 the next cycle, state IDLE, and a new req accepted immediately.
- Byte read, size 0 at addr 0x3: expect arsize 3'b000 and araddr 0x3.
